// File: rtl/uart_prot_pkg.sv
// Shared encodings for the UART protocol-layer transmit engine.
package uart_prot_pkg;

   // Byte source reported on PROT_CFG_ctrl_Txsel
   localparam logic [1:0] TXSEL_IDLE  = 2'd0;
   localparam logic [1:0] TXSEL_ADDR  = 2'd1;
   localparam logic [1:0] TXSEL_FIFO  = 2'd2;
   localparam logic [1:0] TXSEL_STOPF = 2'd3;

   // Level driven on the serial line between frames
   localparam logic UART_IDLE_LVL = 1'b1;

   // Transaction-level (frame) FSM
   typedef enum logic [2:0] {
      F_IDLE,
      F_ADDR,
      F_FETCH,
      F_WAIT,
      F_DATA,
      F_STOPF,
      F_DONE
   } frame_state_e;

   // Bit-level serialiser FSM
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
   } shift_state_e;

endpackage

// File: rtl/uart_prot_tx_shifter.sv
// Serialises one byte: start bit, LSB-first data, optional even parity, 1 or 2 stop bits.
// Baud compare, parity and stop settings are captured at load and held for the whole byte.
module uart_tx_shifter
   import uart_prot_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int BAUD_W = 8
) (
   input  logic              glb_clk,
   input  logic              glb_rstn,
   input  logic              load,
   input  logic [DATA_W-1:0] tx_byte,
   input  logic [BAUD_W-1:0] baud_cmpval,
   input  logic              parity_cfg,
   input  logic              stop_cfg,
   output logic              txd,
   output logic              byte_done
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   shift_state_e      state_q, state_d;
   logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [BAUD_W-1:0] cmp_q, cmp_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              par_en_q, par_en_d;
   logic              stop2_q, stop2_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              par_q, par_d;
   logic              tick;

   // Next-state logic: bit sequencing, baud counting and byte capture
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      cmp_d      = cmp_q;
      bit_cnt_d  = bit_cnt_q;
      par_en_d   = par_en_q;
      stop2_d    = stop2_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      byte_done  = 1'b0;
      tick       = (baud_cnt_q == cmp_q);

      if (state_q == S_IDLE) begin
         baud_cnt_d = '0;
         if (load) begin
            state_d   = S_START;
            shreg_d   = tx_byte;
            par_d     = ^tx_byte;
            cmp_d     = baud_cmpval;
            par_en_d  = parity_cfg;
            stop2_d   = stop_cfg;
            bit_cnt_d = '0;
         end
      end else if (tick) begin
         baud_cnt_d = '0;
         case (state_q)
            S_START: state_d = S_DATA;
            S_DATA: begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d = par_en_q ? S_PARITY : S_STOP1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            S_PARITY: state_d = S_STOP1;
            S_STOP1: begin
               if (stop2_q) begin
                  state_d = S_STOP2;
               end else begin
                  state_d   = S_IDLE;
                  byte_done = 1'b1;
               end
            end
            S_STOP2: begin
               state_d   = S_IDLE;
               byte_done = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         baud_cnt_d = baud_cnt_q + 1'b1;
      end
   end

   // Line level is a pure function of the current bit state
   always_comb begin
      case (state_q)
         S_START:  txd = 1'b0;
         S_DATA:   txd = shreg_q[0];
         S_PARITY: txd = par_q;
         default:  txd = UART_IDLE_LVL;
      endcase
   end

   // Control registers; reset aborts any byte in flight
   always_ff @(posedge glb_clk or negedge glb_rstn) begin
      if (!glb_rstn) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         cmp_q      <= '0;
         bit_cnt_q  <= '0;
         par_en_q   <= 1'b0;
         stop2_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         cmp_q      <= cmp_d;
         bit_cnt_q  <= bit_cnt_d;
         par_en_q   <= par_en_d;
         stop2_q    <= stop2_d;
      end
   end

   // Data registers; only observed while the shifter is active
   always_ff @(posedge glb_clk) begin
      shreg_q <= shreg_d;
      par_q   <= par_d;
   end

endmodule

// File: rtl/uart_prot_tx.sv
// Protocol-layer TX engine: sends slave_addr, every queued FIFO byte, then stop_frame,
// and pulses tx_rst when the transaction is complete.
module uart_prot_tx
   import uart_prot_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int BAUD_W = 8
) (
   input  logic              glb_clk,
   input  logic              glb_rstn,
   input  logic              CFG_PROT_ctrl_Txen,
   input  logic              Tx_FIFO_empty,
   input  logic [DATA_W-1:0] CFG_SEL_data_tx_data,
   input  logic [DATA_W-1:0] slave_addr,
   input  logic [DATA_W-1:0] stop_frame,
   input  logic [BAUD_W-1:0] baud_cmpval,
   input  logic              parity_cfg,
   input  logic              stop_cfg,
   output logic              PROT_CFG_ctrl_tx_r_en,
   output logic              PROT_CFG_ctrl_tx_rst,
   output logic [1:0]        PROT_CFG_ctrl_Txsel,
   output logic              uart_txd,
   output logic              tx_busy
);

   frame_state_e      state_q, state_d;
   logic [1:0]        st_cnt_q, st_cnt_d;
   logic              sh_load;
   logic [DATA_W-1:0] sh_byte;
   logic              byte_done;

   // Frame sequencing. st_cnt counts cycles spent in the current state; it places the
   // address load on the first ADDR cycle and the stop-frame load on the second STOPF
   // cycle so every inter-byte gap is exactly two idle-high cycles.
   always_comb begin
      state_d               = state_q;
      sh_load               = 1'b0;
      sh_byte               = slave_addr;
      PROT_CFG_ctrl_tx_r_en = 1'b0;
      PROT_CFG_ctrl_tx_rst  = 1'b0;
      PROT_CFG_ctrl_Txsel   = TXSEL_IDLE;

      case (state_q)
         F_IDLE: begin
            if (CFG_PROT_ctrl_Txen) state_d = F_ADDR;
         end
         F_ADDR: begin
            PROT_CFG_ctrl_Txsel = TXSEL_ADDR;
            sh_byte             = slave_addr;
            sh_load             = (st_cnt_q == 2'd0);
            if (byte_done) state_d = Tx_FIFO_empty ? F_STOPF : F_FETCH;
         end
         F_FETCH: begin
            PROT_CFG_ctrl_Txsel   = TXSEL_FIFO;
            PROT_CFG_ctrl_tx_r_en = 1'b1;
            state_d               = F_WAIT;
         end
         F_WAIT: begin
            PROT_CFG_ctrl_Txsel = TXSEL_FIFO;
            sh_byte             = CFG_SEL_data_tx_data;
            sh_load             = 1'b1;
            state_d             = F_DATA;
         end
         F_DATA: begin
            PROT_CFG_ctrl_Txsel = TXSEL_FIFO;
            if (byte_done) state_d = Tx_FIFO_empty ? F_STOPF : F_FETCH;
         end
         F_STOPF: begin
            PROT_CFG_ctrl_Txsel = TXSEL_STOPF;
            sh_byte             = stop_frame;
            sh_load             = (st_cnt_q == 2'd1);
            if (byte_done) state_d = F_DONE;
         end
         F_DONE: begin
            PROT_CFG_ctrl_Txsel  = TXSEL_STOPF;
            PROT_CFG_ctrl_tx_rst = 1'b1;
            state_d              = F_IDLE;
         end
         default: state_d = F_IDLE;
      endcase

      if (state_d != state_q) begin
         st_cnt_d = 2'd0;
      end else if (st_cnt_q == 2'd3) begin
         st_cnt_d = st_cnt_q;
      end else begin
         st_cnt_d = st_cnt_q + 2'd1;
      end

      tx_busy = (state_q != F_IDLE);
   end

   // Frame FSM state register
   always_ff @(posedge glb_clk or negedge glb_rstn) begin
      if (!glb_rstn) begin
         state_q  <= F_IDLE;
         st_cnt_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         st_cnt_q <= st_cnt_d;
      end
   end

   uart_tx_shifter #(
      .DATA_W (DATA_W),
      .BAUD_W (BAUD_W)
   ) u_shifter (
      .glb_clk     (glb_clk),
      .glb_rstn    (glb_rstn),
      .load        (sh_load),
      .tx_byte     (sh_byte),
      .baud_cmpval (baud_cmpval),
      .parity_cfg  (parity_cfg),
      .stop_cfg    (stop_cfg),
      .txd         (uart_txd),
      .byte_done   (byte_done)
   );

endmodule
